// File: rtl/border_pkg.sv
// Shared constants for the battle-box border: game-state encodings, target boxes,
// default geometry and the vertical-blank row used as the per-frame strobe point.
package border_pkg;

    localparam logic [1:0] ST_MENU  = 2'b00;
    localparam logic [1:0] ST_FIGHT = 2'b01;
    localparam logic [1:0] ST_DEATH = 2'b10;
    localparam logic [1:0] ST_BLANK = 2'b11;

    typedef struct packed {
        logic [8:0] left;
        logic [8:0] right;
        logic [8:0] top;
        logic [8:0] bottom;
    } box_t;

    localparam box_t MENU_BOX  = '{left: 9'd40,  right: 9'd500, top: 9'd300, bottom: 9'd420};
    localparam box_t FIGHT_BOX = '{left: 9'd240, right: 9'd400, top: 9'd260, bottom: 9'd420};

    localparam int unsigned DEFAULT_THICK = 5;
    localparam int unsigned DEFAULT_STEP  = 4;

    localparam logic [9:0] VBLANK_ROW = 10'd480;

    // Death and blank have no box of their own: they freeze wherever the edges are.
    function automatic box_t target_box(input logic [1:0] st, input box_t cur);
        box_t tgt;
        case (st)
            ST_MENU:  tgt = MENU_BOX;
            ST_FIGHT: tgt = FIGHT_BOX;
            default:  tgt = cur;
        endcase
        return tgt;
    endfunction

endpackage

// File: rtl/border_edge_stepper.sv
// One animated edge coordinate; moves toward its target on each frame strobe.
// BORDER_ANIM_EN selects stepped motion; otherwise the edge jumps straight to target.
module border_edge_stepper
    import border_pkg::*;
#(
    parameter logic [8:0]  RESET_VAL = 9'd0,
    parameter int unsigned STEP      = DEFAULT_STEP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       strobe,
    input  logic [8:0] target,
    output logic [8:0] pos
);

`ifdef BORDER_ANIM_EN
    localparam logic [8:0] STEP_W = 9'(STEP);
`else
    // A full-range step always lands on the target in a single strobe.
    localparam logic [8:0] STEP_W = 9'(STEP) | 9'h1FF;
`endif

    logic [8:0] pos_q;
    logic [8:0] pos_d;
    logic [8:0] diff;

    always_comb begin
        pos_d = pos_q;
        diff  = '0;
        if (pos_q < target) begin
            diff  = target - pos_q;
            pos_d = (diff >= STEP_W) ? pos_q + STEP_W : target;
        end else if (pos_q > target) begin
            diff  = pos_q - target;
            pos_d = (diff >= STEP_W) ? pos_q - STEP_W : target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q <= RESET_VAL;
        end else if (strobe) begin
            pos_q <= pos_d;
        end
    end

    assign pos = pos_q;

endmodule

// File: rtl/border_frame_sprite.sv
// Battle-box border: animates four edges toward the per-state box once per frame and
// flags pixels on the frame band. Animation style is set by BORDER_ANIM_EN.
module border_frame_sprite
    import border_pkg::*;
#(
    parameter int unsigned THICK = DEFAULT_THICK,
    parameter int unsigned STEP  = DEFAULT_STEP
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic [1:0] state,
    output logic       borderSpriteOn,
    output logic [8:0] leftBorder,
    output logic [8:0] rightBorder,
    output logic [8:0] topBorder,
    output logic [8:0] bottomBorder
);

    localparam logic [9:0] THICK_W = 10'(THICK);

    logic vblank_hit;
    logic vblank_q;
    logic strobe_q;
    box_t cur_box;
    box_t tgt_box;

    assign vblank_hit = (x == 10'd0) && (y == VBLANK_ROW);

    // Registered rising-edge detect gives exactly one strobe per frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vblank_q <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            vblank_q <= vblank_hit;
            strobe_q <= vblank_hit && !vblank_q;
        end
    end

    assign cur_box = '{left: leftBorder, right: rightBorder, top: topBorder,
                       bottom: bottomBorder};
    assign tgt_box = target_box(state, cur_box);

    border_edge_stepper #(.RESET_VAL(MENU_BOX.left), .STEP(STEP)) u_left (
        .clk    (clk),
        .reset  (reset),
        .strobe (strobe_q),
        .target (tgt_box.left),
        .pos    (leftBorder)
    );

    border_edge_stepper #(.RESET_VAL(MENU_BOX.right), .STEP(STEP)) u_right (
        .clk    (clk),
        .reset  (reset),
        .strobe (strobe_q),
        .target (tgt_box.right),
        .pos    (rightBorder)
    );

    border_edge_stepper #(.RESET_VAL(MENU_BOX.top), .STEP(STEP)) u_top (
        .clk    (clk),
        .reset  (reset),
        .strobe (strobe_q),
        .target (tgt_box.top),
        .pos    (topBorder)
    );

    border_edge_stepper #(.RESET_VAL(MENU_BOX.bottom), .STEP(STEP)) u_bottom (
        .clk    (clk),
        .reset  (reset),
        .strobe (strobe_q),
        .target (tgt_box.bottom),
        .pos    (bottomBorder)
    );

    logic [9:0] l10, r10, t10, b10;
    logic       in_outer;
    logic       in_inner;
    logic       pixel_d;
    logic       pixel_q;

    assign l10 = {1'b0, leftBorder};
    assign r10 = {1'b0, rightBorder};
    assign t10 = {1'b0, topBorder};
    assign b10 = {1'b0, bottomBorder};

    always_comb begin
        in_outer = (x >= l10 - THICK_W) && (x <= r10 + THICK_W) &&
                   (y >= t10 - THICK_W) && (y <= b10 + THICK_W);
        in_inner = (x >= l10) && (x <= r10) && (y >= t10) && (y <= b10);
        pixel_d  = in_outer && !in_inner && (state != ST_DEATH) && (state != ST_BLANK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_q <= 1'b0;
        end else begin
            pixel_q <= pixel_d;
        end
    end

    assign borderSpriteOn = pixel_q;

endmodule

// File: tb/tb_border_frame_sprite.sv
// Self-checking bench for border_frame_sprite: directed plan steps plus randomized states,
// strobes and pixels checked against an arithmetic box model.
module tb_border_frame_sprite;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] state;
    logic       bso;
    logic [8:0] lb, rb, tb_edge, bb;

    int checks   = 0;
    int failures = 0;
    int m_edge[4];  // model L, R, T, B

    always #5 clk = ~clk;

    border_frame_sprite dut (
        .clk            (clk),
        .reset          (reset),
        .x              (x),
        .y              (y),
        .state          (state),
        .borderSpriteOn (bso),
        .leftBorder     (lb),
        .rightBorder    (rb),
        .topBorder      (tb_edge),
        .bottomBorder   (bb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_edge[0] = 40; m_edge[1] = 500; m_edge[2] = 300; m_edge[3] = 420;
    endtask

    task automatic model_strobe(input int st);
        int tgt[4];
        int d;
        if (st == 0) begin
            tgt[0] = 40;  tgt[1] = 500; tgt[2] = 300; tgt[3] = 420;
        end else if (st == 1) begin
            tgt[0] = 240; tgt[1] = 400; tgt[2] = 260; tgt[3] = 420;
        end else begin
            for (int i = 0; i < 4; i++) tgt[i] = m_edge[i];
        end
        for (int i = 0; i < 4; i++) begin
            d = tgt[i] - m_edge[i];
`ifdef BORDER_ANIM_EN
            if (d >= 4) m_edge[i] += 4;
            else if (d <= -4) m_edge[i] -= 4;
            else m_edge[i] = tgt[i];
`else
            m_edge[i] = tgt[i];
`endif
        end
    endtask

    function automatic logic model_pixel(input int xi, input int yi, input int st);
        logic outer, inner;
        outer = xi >= m_edge[0] - 5 && xi <= m_edge[1] + 5 &&
                yi >= m_edge[2] - 5 && yi <= m_edge[3] + 5;
        inner = xi >= m_edge[0] && xi <= m_edge[1] && yi >= m_edge[2] && yi <= m_edge[3];
        return outer && !inner && st < 2;
    endfunction

    task automatic check_edges(input string tag);
        check({tag, ".L"}, 32'(lb), 32'(m_edge[0]));
        check({tag, ".R"}, 32'(rb), 32'(m_edge[1]));
        check({tag, ".T"}, 32'(tb_edge), 32'(m_edge[2]));
        check({tag, ".B"}, 32'(bb), 32'(m_edge[3]));
    endtask

    task automatic check_box(input string tag, input int l, input int r, input int t, input int b);
        check({tag, ".L"}, 32'(lb), 32'(l));
        check({tag, ".R"}, 32'(rb), 32'(r));
        check({tag, ".T"}, 32'(tb_edge), 32'(t));
        check({tag, ".B"}, 32'(bb), 32'(b));
    endtask

    task automatic do_strobe();
        x = 10'd0; y = 10'd480;
        tick();
        tick();
        x = 10'd1; y = 10'd0;
        tick();
        tick();
        model_strobe(int'(state));
    endtask

    task automatic pixel_check(input string tag, input int xi, input int yi);
        x = 10'(xi); y = 10'(yi);
        tick();
        check(tag, 32'(bso), 32'(model_pixel(xi, yi, int'(state))));
    endtask

    initial begin
        int xs[6];
        int ys_exp[6];
        int n, px, py;
        reset = 1'b1; x = 10'd1; y = 10'd0; state = 2'b00;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_edges("reset");
        x = 10'd0; y = 10'd0;
        tick();
        check("reset_pix", 32'(bso), 32'd0);

        // Menu sweep at y = 350
        xs = '{34, 35, 39, 40, 505, 506};
        ys_exp = '{0, 1, 1, 0, 1, 0};
        for (int i = 0; i < 6; i++) begin
            x = 10'(xs[i]); y = 10'd350;
            tick();
            check($sformatf("sweep_x%0d", xs[i]), 32'(bso), 32'(ys_exp[i]));
        end

        // Menu -> fight
        state = 2'b01;
        do_strobe();
`ifdef BORDER_ANIM_EN
        check_box("fight1", 44, 496, 296, 420);
`else
        check_box("fight1", 240, 400, 260, 420);
`endif
        check_edges("fight1_model");
        for (int i = 0; i < 9; i++) do_strobe();
        check("fight10.T", 32'(tb_edge), 32'd260);
        for (int i = 0; i < 40; i++) do_strobe();
        check_box("fight50", 240, 400, 260, 420);
        for (int i = 0; i < 3; i++) do_strobe();
        check_box("fight53", 240, 400, 260, 420);
        pixel_check("fight_pix_a", 237, 300);
        pixel_check("fight_pix_b", 300, 425);

        // Death and blank freeze edges and blank the band
        for (int s = 3; s >= 2; s--) begin
            state = 2'(s);
            x = 10'd38; y = 10'd350;
            tick();
            check($sformatf("st%0d_pix", s), 32'(bso), 32'd0);
            pixel_check($sformatf("st%0d_band", s), 237, 300);
            for (int i = 0; i < 5; i++) do_strobe();
            check_box($sformatf("st%0d_hold", s), 240, 400, 260, 420);
        end

        // Randomized states, strobe counts and pixels
        for (int it = 0; it < 25; it++) begin
            state = 2'($urandom_range(0, 3));
            n = $urandom_range(0, 8);
            for (int i = 0; i < n; i++) do_strobe();
            check_edges($sformatf("rnd%0d", it));
            for (int k = 0; k < 4; k++) begin
                px = $urandom_range(m_edge[0] - 10, m_edge[1] + 10);
                py = $urandom_range(m_edge[2] - 10, m_edge[3] + 10);
                pixel_check($sformatf("rnd%0d_pix(%0d,%0d)", it, px, py), px, py);
            end
        end

        // Asynchronous reset mid-animation
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        state = 2'b01;
        for (int i = 0; i < 20; i++) do_strobe();
`ifdef BORDER_ANIM_EN
        check("pre_reset.L", 32'(lb), 32'd120);
`endif
        check_edges("pre_reset");
        x = 10'd300; y = 10'd257;
        tick();
        check("pre_reset_pix", 32'(bso), 32'(model_pixel(300, 257, 1)));
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_box("async_reset", 40, 500, 300, 420);
        check("async_reset_pix", 32'(bso), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
